// File: rtl/aes_ctr_axil_seq.sv
// AXI4-Lite register front end and CTR-mode sequencer for an external AES core.
// Computes CT = PT ^ E(K[KEY_SEL], CTR) block by block and raises irq when done.
module aes_ctr_axil_seq #(
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int NUM_KEYS           = 3,
  parameter int KEY_BITS           = 192,
  parameter int CTR_BITS           = 32
) (
  input  logic                          s00_axi_aclk,
  input  logic                          s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
  input  logic                          s00_axi_awvalid,
  output logic                          s00_axi_awready,
  input  logic [31:0]                   s00_axi_wdata,
  input  logic [3:0]                    s00_axi_wstrb,
  input  logic                          s00_axi_wvalid,
  output logic                          s00_axi_wready,
  output logic [1:0]                    s00_axi_bresp,
  output logic                          s00_axi_bvalid,
  input  logic                          s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
  input  logic                          s00_axi_arvalid,
  output logic                          s00_axi_arready,
  output logic [31:0]                   s00_axi_rdata,
  output logic [1:0]                    s00_axi_rresp,
  output logic                          s00_axi_rvalid,
  input  logic                          s00_axi_rready,
  output logic [KEY_BITS-1:0]           core_key,
  output logic [1:0]                    core_keylen,
  output logic [127:0]                  core_block,
  output logic                          core_init,
  output logic                          core_next,
  input  logic                          core_ready,
  input  logic                          core_result_valid,
  input  logic [127:0]                  core_result,
  output logic                          irq
);

  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int KW       = KEY_BITS / 32;
  localparam int KEY_BASE = 16;
  localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_BITS);
  localparam logic [1:0] KEYLEN = (KEY_BITS == 256) ? 2'd2 : (KEY_BITS == 192) ? 2'd1 : 2'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_KEY_WAIT, S_KEY_RUN, S_ENC_WAIT, S_ENC_RUN, S_WAIT_PT, S_DONE
  } state_t;

  state_t state;
  logic        irq_en, done, ct_valid, key_err, key_dirty;
  logic [31:0] key_sel;
  logic [15:0] nblk, remaining;
  // Word 0 of every multi-word field sits at the MS packed index.
  logic [3:0][31:0]                   pt, ctr, ct;
  logic [NUM_KEYS-1:0][KW-1:0][31:0]  keys;

  logic        aw_rdy;
  logic        wr, busy, start_req, clr_req, pt_wr_ok;
  logic [31:0] wi, ri, wm, rd_word;
  logic        unused_addr_lsb;

  assign s00_axi_awready = aw_rdy;
  assign s00_axi_wready  = aw_rdy;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_rresp   = 2'b00;
  assign core_keylen     = KEYLEN;
  assign core_block      = ctr;
  assign irq             = done & irq_en;
  assign unused_addr_lsb = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign wr        = aw_rdy & s00_axi_awvalid & s00_axi_wvalid;
  assign wi        = 32'(s00_axi_awaddr[AW-1:2]);
  assign ri        = 32'(s00_axi_araddr[AW-1:2]);
  assign wm        = {{8{s00_axi_wstrb[3]}}, {8{s00_axi_wstrb[2]}},
                      {8{s00_axi_wstrb[1]}}, {8{s00_axi_wstrb[0]}}};
  assign busy      = (state != S_IDLE);
  assign start_req = wr && (wi == 32'd0) && s00_axi_wstrb[0] && s00_axi_wdata[0];
  assign clr_req   = wr && (wi == 32'd0) && s00_axi_wstrb[0] && s00_axi_wdata[1];
  assign pt_wr_ok  = (state == S_IDLE) || (state == S_WAIT_PT);

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [31:0] m);
    return (old & ~m) | (d & m);
  endfunction

  always_comb begin
    core_key = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      if (key_sel == 32'(k)) core_key = keys[k];
  end

  always_comb begin
    rd_word = '0;
    case (ri)
      32'd0:   rd_word = {29'd0, irq_en, 2'd0};
      32'd1:   rd_word = {28'd0, key_err, ct_valid, done, busy};
      32'd2:   rd_word = key_sel;
      32'd3:   rd_word = {16'd0, nblk};
      default: rd_word = '0;
    endcase
    for (int j = 0; j < 4; j++) begin
      if (ri == 32'(4 + j))  rd_word = pt[3-j];
      if (ri == 32'(8 + j))  rd_word = ctr[3-j];
      if (ri == 32'(12 + j)) rd_word = ct[3-j];
    end
    for (int k = 0; k < NUM_KEYS; k++)
      for (int j = 0; j < KW; j++)
        if (ri == 32'(KEY_BASE + k*KW + j)) rd_word = keys[k][KW-1-j];
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      state          <= S_IDLE;
      irq_en         <= 1'b0;
      done           <= 1'b0;
      ct_valid       <= 1'b0;
      key_err        <= 1'b0;
      key_dirty      <= 1'b1;
      key_sel        <= '0;
      nblk           <= '0;
      remaining      <= '0;
      pt             <= '0;
      ctr            <= '0;
      ct             <= '0;
      keys           <= '0;
      aw_rdy         <= 1'b0;
      s00_axi_bvalid <= 1'b0;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid <= 1'b0;
      s00_axi_rdata  <= '0;
      core_init      <= 1'b0;
      core_next      <= 1'b0;
    end else begin
      core_init <= 1'b0;
      core_next <= 1'b0;

      aw_rdy <= ~aw_rdy & s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_bvalid;
      if (wr)                  s00_axi_bvalid <= 1'b1;
      else if (s00_axi_bready) s00_axi_bvalid <= 1'b0;

      s00_axi_arready <= ~s00_axi_arready & s00_axi_arvalid & ~s00_axi_rvalid;
      if (s00_axi_arready && s00_axi_arvalid) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rdata  <= rd_word;
      end else if (s00_axi_rready) begin
        s00_axi_rvalid <= 1'b0;
      end

      if (wr) begin
        if (wi == 32'd0 && s00_axi_wstrb[0]) irq_en <= s00_axi_wdata[2];
        if (clr_req) done <= 1'b0;
        if (wi == 32'd2 && !busy) begin
          key_sel   <= merge(key_sel, s00_axi_wdata, wm);
          key_dirty <= 1'b1;
        end
        if (wi == 32'd3 && !busy)
          nblk <= (nblk & ~wm[15:0]) | (s00_axi_wdata[15:0] & wm[15:0]);
        for (int j = 0; j < 4; j++) begin
          if (wi == 32'(4 + j) && pt_wr_ok) pt[3-j]  <= merge(pt[3-j], s00_axi_wdata, wm);
          if (wi == 32'(8 + j) && !busy)    ctr[3-j] <= merge(ctr[3-j], s00_axi_wdata, wm);
        end
        for (int k = 0; k < NUM_KEYS; k++)
          for (int j = 0; j < KW; j++)
            if (wi == 32'(KEY_BASE + k*KW + j) && !busy) begin
              keys[k][KW-1-j] <= merge(keys[k][KW-1-j], s00_axi_wdata, wm);
              if (key_sel == 32'(k)) key_dirty <= 1'b1;
            end
      end

      // FSM updates come last so they take priority over register writes.
      case (state)
        S_IDLE: if (start_req) begin
          if (key_sel >= 32'(NUM_KEYS)) begin
            key_err <= 1'b1;
          end else begin
            key_err   <= 1'b0;
            done      <= 1'b0;
            ct_valid  <= 1'b0;
            remaining <= nblk;
            if (nblk == 16'd0)  state <= S_DONE;
            else if (key_dirty) state <= S_KEY_WAIT;
            else                state <= S_ENC_WAIT;
          end
        end
        S_KEY_WAIT: if (core_ready) begin
          core_init <= 1'b1;
          state     <= S_KEY_RUN;
        end
        // Skip the pulse cycle: the core has not yet dropped ready.
        S_KEY_RUN: if (!core_init && core_ready) begin
          key_dirty <= 1'b0;
          state     <= S_ENC_WAIT;
        end
        S_ENC_WAIT: if (core_ready) begin
          core_next <= 1'b1;
          state     <= S_ENC_RUN;
        end
        // A result_valid still high from the previous block is ignored during the pulse.
        S_ENC_RUN: if (!core_next && core_result_valid) begin
          ct        <= pt ^ core_result;
          ct_valid  <= 1'b1;
          ctr       <= (ctr & ~CTR_MASK) | ((ctr + 128'd1) & CTR_MASK);
          remaining <= remaining - 16'd1;
          state     <= (remaining == 16'd1) ? S_DONE : S_WAIT_PT;
        end
        S_WAIT_PT: if (wr && wi == 32'd7) begin
          ct_valid <= 1'b0;
          state    <= S_ENC_WAIT;
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
